// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM -> WB pipeline bundle.
// The MEM side drives the mem_* fields. The WB register drives the wb_* fields
// toward the register file write port (waddr/we/wdata), HI/LO and CP0.
//   master modport : MEM-stage side (drives mem_*, observes wb_*)
//   slave modport  : the mem_wb register (samples mem_*, drives wb_*)
// There is no handshake. The bundle moves every clock, and only the
// pipeline controller's stall/flush (plain ports on mem_wb) gate it.
interface mem_wb_if;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        mem_llbit_we;
  logic        mem_llbit_value;
  logic        mem_cp0_reg_we;
  logic [4:0]  mem_cp0_reg_addr;
  logic [31:0] mem_cp0_reg_data;

  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        wb_cp0_reg_we;
  logic [4:0]  wb_cp0_reg_addr;
  logic [31:0] wb_cp0_reg_data;

  modport master (
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           mem_llbit_we, mem_llbit_value,
           mem_cp0_reg_we, mem_cp0_reg_addr, mem_cp0_reg_data,
    input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
           wb_cp0_reg_we, wb_cp0_reg_addr, wb_cp0_reg_data
  );

  modport slave (
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           mem_llbit_we, mem_llbit_value,
           mem_cp0_reg_we, mem_cp0_reg_addr, mem_cp0_reg_data,
    output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
           wb_cp0_reg_we, wb_cp0_reg_addr, wb_cp0_reg_data
  );
endinterface

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register with stall/flush handling and the LL/SC
// link bit (LLbit).
// Ports:
//   clk     : core clock, all state on the rising edge
//   rst     : synchronous active-high reset
//   stall   : controller stall vector, bit 4 = MEM stalled, bit 5 = WB stalled
//   flush   : exception flush, synchronous
//   bus     : mem_wb_if slave (mem_* in, wb_* out, all wb_* are flop outputs)
//   llbit_o : current link bit, bypassed from the WB-stage LL write
module mem_wb (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       flush,
  mem_wb_if.slave    bus,
  output logic       llbit_o
);

  logic wb_llbit_we;
  logic wb_llbit_value;
  logic llbit_q;

  // Only the MEM/WB bits of the stall vector matter at this boundary.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  // MEM stalled while WB runs: WB must receive a bubble, not the stalled
  // instruction again.
  logic bubble;
  assign bubble = stall[4] & ~stall[5];

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      bus.wb_wd           <= 5'd0;
      bus.wb_wreg         <= 1'b0;
      bus.wb_wdata        <= 32'd0;
      bus.wb_hi           <= 32'd0;
      bus.wb_lo           <= 32'd0;
      bus.wb_whilo        <= 1'b0;
      wb_llbit_we         <= 1'b0;
      wb_llbit_value      <= 1'b0;
      bus.wb_cp0_reg_we   <= 1'b0;
      bus.wb_cp0_reg_addr <= 5'd0;
      bus.wb_cp0_reg_data <= 32'd0;
    end else if (!stall[4]) begin
      // stall[4]=0 passes regardless of stall[5].
      bus.wb_wd           <= bus.mem_wd;
      bus.wb_wreg         <= bus.mem_wreg;
      bus.wb_wdata        <= bus.mem_wdata;
      bus.wb_hi           <= bus.mem_hi;
      bus.wb_lo           <= bus.mem_lo;
      bus.wb_whilo        <= bus.mem_whilo;
      wb_llbit_we         <= bus.mem_llbit_we;
      wb_llbit_value      <= bus.mem_llbit_value;
      bus.wb_cp0_reg_we   <= bus.mem_cp0_reg_we;
      bus.wb_cp0_reg_addr <= bus.mem_cp0_reg_addr;
      bus.wb_cp0_reg_data <= bus.mem_cp0_reg_data;
    end
    // Both stalled: hold. Write enables stay asserted, and the repeated
    // identical write is harmless.
  end

  // Link bit. An exception breaks the link.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      llbit_q <= 1'b0;
    end else if (wb_llbit_we) begin
      llbit_q <= wb_llbit_value;
    end
  end

  // Bypass so that an SC in MEM sees the LL currently in WB.
  always_comb begin
    llbit_o = llbit_q;
    if (rst || flush) begin
      llbit_o = 1'b0;
    end else if (wb_llbit_we) begin
      llbit_o = wb_llbit_value;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed bench for mem_wb with immediate-assertion checks.
module tb_mem_wb;

  logic       clk;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  logic       llbit_o;

  mem_wb_if bus ();

  mem_wb dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .bus     (bus.slave),
    .llbit_o (llbit_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic cp0_we, input logic [4:0] cp0_addr, input logic [31:0] cp0_data,
                       input logic ll_we, input logic ll_val);
    bus.mem_wd           = wd;
    bus.mem_wreg         = wreg;
    bus.mem_wdata        = wdata;
    bus.mem_whilo        = whilo;
    bus.mem_hi           = hi;
    bus.mem_lo           = lo;
    bus.mem_cp0_reg_we   = cp0_we;
    bus.mem_cp0_reg_addr = cp0_addr;
    bus.mem_cp0_reg_data = cp0_data;
    bus.mem_llbit_we     = ll_we;
    bus.mem_llbit_value  = ll_val;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // checks the whole slot against expected field values
  task automatic chk_slot(input string tag, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                          input logic [31:0] lo, input logic cp0_we, input logic [4:0] cp0_addr,
                          input logic [31:0] cp0_data);
    chk({tag, ".wd"},       {27'd0, bus.wb_wd},           {27'd0, wd});
    chk({tag, ".wreg"},     {31'd0, bus.wb_wreg},         {31'd0, wreg});
    chk({tag, ".wdata"},    bus.wb_wdata,                 wdata);
    chk({tag, ".whilo"},    {31'd0, bus.wb_whilo},        {31'd0, whilo});
    chk({tag, ".hi"},       bus.wb_hi,                    hi);
    chk({tag, ".lo"},       bus.wb_lo,                    lo);
    chk({tag, ".cp0_we"},   {31'd0, bus.wb_cp0_reg_we},   {31'd0, cp0_we});
    chk({tag, ".cp0_addr"}, {27'd0, bus.wb_cp0_reg_addr}, {27'd0, cp0_addr});
    chk({tag, ".cp0_data"}, bus.wb_cp0_reg_data,          cp0_data);
  endtask

  initial begin
    // reset with busy inputs
    rst = 1'b1; stall = 6'd0; flush = 1'b0;
    drive(5'd31, 1'b1, 32'hFFFF_0000, 1'b1, 32'h1, 32'h2, 1'b1, 5'd9, 32'h3, 1'b1, 1'b1);
    step(); step();
    chk_slot("reset", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("reset.llbit", {31'd0, llbit_o}, 32'd0);

    // pass, one-cycle latency
    rst = 1'b0;
    drive(5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step();
    chk_slot("pass1", 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(5'd3, 1'b1, 32'h0000_1234, 1'b1, 32'hA, 32'hB, 1'b1, 5'd12, 32'h55, 1'b0, 1'b0);
    step();
    chk_slot("pass2", 5'd3, 1'b1, 32'h0000_1234, 1'b1, 32'hA, 32'hB, 1'b1, 5'd12, 32'h55);

    // hold for three edges while mem_* changes
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      drive(5'(9 + i), 1'b0, 32'hFFFF_0000 + 32'(i), 1'b0, 32'hC, 32'hD, 1'b0, 5'd1, 32'h77,
            1'b0, 1'b0);
      step();
      chk_slot("hold", 5'd3, 1'b1, 32'h0000_1234, 1'b1, 32'hA, 32'hB, 1'b1, 5'd12, 32'h55);
    end
    stall = 6'd0;
    step();
    chk_slot("release", 5'd11, 1'b0, 32'hFFFF_0002, 1'b0, 32'hC, 32'hD, 1'b0, 5'd1, 32'h77);

    // bubble: MEM stalled, WB running
    drive(5'd3, 1'b1, 32'h0000_0033, 1'b1, 32'h5, 32'h6, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
    step();
    chk_slot("prebubble", 5'd3, 1'b1, 32'h0000_0033, 1'b1, 32'h5, 32'h6, 1'b1, 5'd4, 32'h44);
    stall = 6'b010000;
    drive(5'd7, 1'b1, 32'h0000_0077, 1'b1, 32'h7, 32'h8, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
    step();
    chk_slot("bubble", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // stall[4]=0 with stall[5]=1 still passes
    stall = 6'b100000;
    step();
    chk_slot("pass_s5", 5'd7, 1'b1, 32'h0000_0077, 1'b1, 32'h7, 32'h8, 1'b1, 5'd6, 32'h66);

    // flush beats hold
    stall = 6'b110000; flush = 1'b1;
    step();
    chk_slot("flush", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("flush.llbit", {31'd0, llbit_o}, 32'd0);
    stall = 6'd0; flush = 1'b0;

    // short pass stream against the expected queue
    for (int i = 0; i < 6; i++) begin
      drive(5'(i), 1'b1, $urandom, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      exp_q.push_back(bus.mem_wdata);
      step();
      chk("stream.wdata", bus.wb_wdata, exp_q.pop_front());
    end

    // LLbit: set, bypass, persist, overwrite with 0
    drive(5'd2, 1'b1, 32'h1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    step();
    chk("ll.bypass1", {31'd0, llbit_o}, 32'd1);
    bus.mem_llbit_we = 1'b0; bus.mem_llbit_value = 1'b0;
    step();
    chk("ll.q1", {31'd0, llbit_o}, 32'd1);
    step();
    chk("ll.q1b", {31'd0, llbit_o}, 32'd1);
    bus.mem_llbit_we = 1'b1; bus.mem_llbit_value = 1'b0;
    step();
    chk("ll.bypass0", {31'd0, llbit_o}, 32'd0);
    bus.mem_llbit_we = 1'b0;
    step();
    chk("ll.q0", {31'd0, llbit_o}, 32'd0);

    // LLbit: set again, then flush clears it combinationally and persistently
    bus.mem_llbit_we = 1'b1; bus.mem_llbit_value = 1'b1;
    step();
    bus.mem_llbit_we = 1'b0; bus.mem_llbit_value = 1'b0;
    step();
    chk("ll.q1c", {31'd0, llbit_o}, 32'd1);
    flush = 1'b1;
    #1;
    chk("ll.flush_comb", {31'd0, llbit_o}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("ll.after_flush", {31'd0, llbit_o}, 32'd0);
    step();
    chk("ll.after_flush2", {31'd0, llbit_o}, 32'd0);

    // reset mid-stream with everything nonzero
    drive(5'd17, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h11, 32'h22, 1'b1, 5'd13, 32'h33, 1'b1, 1'b1);
    step();
    chk("prerst.wd", {27'd0, bus.wb_wd}, 32'd17);
    chk("prerst.llbit", {31'd0, llbit_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst.llbit_comb", {31'd0, llbit_o}, 32'd0);
    step();
    chk_slot("midrst", 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    bus.mem_llbit_we = 1'b0;
    #1;
    chk("midrst.llbit", {31'd0, llbit_o}, 32'd0);
    step();
    chk("postrst.wd", {27'd0, bus.wb_wd}, 32'd17);
    chk("postrst.llbit", {31'd0, llbit_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
# mem_wb

MEM/WB pipeline register for the five-stage core: captures the MEM stage's results each clock and presents them to the writeback consumers, i.e. the register file write port (`we`/`waddr`/`wdata`), the HI/LO register, and CP0. It implements the pipeline controller's stall and flush semantics for the WB boundary. It also owns the LL/SC link bit (LLbit) with a same-cycle bypass.

## Interface
Parameters: none. Widths: `RegBus` = 32, `RegAddrBus` = 5.

- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1)
- stall  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled; other bits ignored
- flush  in  1  exception flush; synchronous
- mem_wd  in  5  destination GPR address
- mem_wreg  in  1  GPR write enable
- mem_wdata  in  32  GPR write data
- mem_hi, mem_lo  in  32 each  HI/LO write data
- mem_whilo  in  1  HI/LO write enable
- mem_llbit_we  in  1  LLbit write enable (LL/SC)
- mem_llbit_value  in  1  LLbit value
- mem_cp0_reg_we  in  1  CP0 write enable
- mem_cp0_reg_addr  in  5  CP0 register address
- mem_cp0_reg_data  in  32  CP0 write data
- wb_wd, wb_wreg, wb_wdata  out  5/1/32  to regfile `waddr`/`we`/`wdata`
- wb_hi, wb_lo, wb_whilo  out  32/32/1  to HI/LO
- wb_cp0_reg_we, wb_cp0_reg_addr, wb_cp0_reg_data  out  1/5/32  to CP0
- llbit_o  out  1  current link bit, bypassed

## Operation
- The block holds one pipeline slot: all `wb_*` outputs plus internal `wb_llbit_we` and `wb_llbit_value`.
- Slot update at each rising edge uses this priority:
  1. rst=1: every slot field is 0 (`wb_wd`=0, `wb_wreg`=0, `wb_wdata`=0, `wb_hi`=`wb_lo`=0, `wb_whilo`=0, `wb_llbit_we`=0, `wb_cp0_*`=0).
  2. flush=1: slot zeroed, same as reset. This kills the instruction entering WB.
  3. stall[4]=1 and stall[5]=0: bubble. Slot is zeroed, so no write enable is asserted downstream.
  4. stall[4]=1 and stall[5]=1: hold. Slot is unchanged.
  5. stall[4]=0: pass. Every field loads from its `mem_*` counterpart. stall[4]=0 with stall[5]=1 is never generated by the controller, but it is defined as pass.
- LLbit register (`llbit_q`) at each rising edge, in priority order:
  - rst=1 sets it to 0.
  - flush=1 sets it to 0. An exception breaks the link.
  - Otherwise, if `wb_llbit_we`=1, it loads `wb_llbit_value`.
  - Otherwise it holds.
- `llbit_o` is combinational:
  - 0 when rst=1 or flush=1.
  - Otherwise `wb_llbit_value` when `wb_llbit_we`=1. This lets a WB-stage LL be visible to a following SC in MEM.
  - Otherwise `llbit_q`.
- No data transformation: fields are registered verbatim with no width changes. The block does not filter `wb_wd`=0; the regfile suppresses writes to $0.

## Timing
- Latency: 1 cycle. `mem_*` sampled at edge N appears on `wb_*` after edge N. The regfile commits it at edge N+1.
- Every `wb_*` output is a flop output with no combinational path from inputs. `llbit_o` is the only combinational output; it depends on rst, flush, and internal state only.
- Reset value of all outputs is 0, including `llbit_o`.
- Hold keeps the write enables asserted for every held cycle. This is a repeated identical write, which is harmless.
- Flush and stall in the same cycle: flush wins.
- Reset mid-hold: slot and LLbit are cleared at that edge, and the held instruction is lost.
- `wb_llbit_we` held across a stall rewrites the same value, so the LLbit is unchanged.

## Test plan
- Pass: rst released; mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, stall=0. One edge later: wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF. Next input appears on the following edge.
- Bubble: slot holds wd=3/wreg=1. Apply stall=6'b010000 with new mem_wd=7/wreg=1. After the edge: wb_wreg=0, wb_whilo=0, wb_cp0_reg_we=0, wb_wdata=0.
- Hold: slot holds wd=3, wdata=0x1234, whilo=1, hi=0xA, lo=0xB. stall=6'b110000 for 3 edges while mem_* change → all wb_* remain unchanged. Releasing to stall=0 loads the current mem_* on the next edge.
- Flush priority: stall=6'b110000 and flush=1 with a valid slot. After the edge: all wb_* are 0, llbit_o=0.
- LLbit: pass mem_llbit_we=1, value=1. After the edge: llbit_o=1 immediately (bypass). With the next input having llbit_we=0, llbit_o stays 1 from `llbit_q`. Pulse flush → llbit_o=0 in the same cycle, and it remains 0 afterwards.
- Reset: apply rst=1 for one edge mid-stream with all mem_* nonzero → all outputs 0 after the edge. llbit_o reads 0 while rst=1.
